// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I cores: FSM state encoding,
// opcodes, ALU control codes and a legality check for decoded opcodes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic isLegalOp(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: isLegalOp = 1'b1;
      default:                                  isLegalOp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps the FSM's ALUOp plus instruction fields to an
// ALUControl code. Shared with the pipelined core.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       opB5,
  input  logic       funct7b5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      2'b01: aluControl = ALU_SUB;
      2'b10: begin
        case (funct3)
          // Only R-type (op[5]=1) can request sub; addi ignores IR[30]
          3'b000:  aluControl = (opB5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore main FSM, immediate-format decode and
// the shared ALU decoder. Reset forces all enables low within the same cycle.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       InstrRetired,
  output logic       IllegalOp
);

  state_t stateReg, stateNext, outState;
  logic [1:0] aluOp;
  logic       branch, pcUpdate, irWriteFsm, regWriteFsm, memWriteFsm;
  logic       retiredFsm, illegalFsm;
  logic       opLegal;

  assign opLegal = isLegalOp(op);

  always_ff @(posedge clk) begin
    if (reset) stateReg <= S_FETCH;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      S_FETCH: stateNext = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_R:         stateNext = S_EXECR;
          OP_I:         stateNext = S_EXECI;
          OP_JAL:       stateNext = S_JAL;
          OP_BEQ:       stateNext = S_BEQ;
          default:      stateNext = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   stateNext = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  stateNext = S_MEMWB;
      S_MEMWB:    stateNext = S_FETCH;
      S_MEMWRITE: stateNext = S_FETCH;
      S_EXECR:    stateNext = S_ALUWB;
      S_EXECI:    stateNext = S_ALUWB;
      S_JAL:      stateNext = S_ALUWB;
      S_ALUWB:    stateNext = S_FETCH;
      S_BEQ:      stateNext = S_FETCH;
      S_HALT:     stateNext = S_HALT;
      default:    stateNext = S_FETCH;
    endcase
  end

  // While reset is held the outputs decode as FETCH, even mid-instruction
  assign outState = reset ? S_FETCH : stateReg;

  always_comb begin
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    aluOp       = 2'b00;
    branch      = 1'b0;
    pcUpdate    = 1'b0;
    irWriteFsm  = 1'b0;
    regWriteFsm = 1'b0;
    memWriteFsm = 1'b0;
    retiredFsm  = 1'b0;
    illegalFsm  = 1'b0;
    case (outState)
      S_FETCH: begin
        irWriteFsm = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcUpdate   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        illegalFsm = ~opLegal;
        retiredFsm = ~opLegal && (ILLEGAL_TRAP == 0);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteFsm = 1'b1;
        retiredFsm  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteFsm = 1'b1;
        retiredFsm  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      S_ALUWB: begin
        regWriteFsm = 1'b1;
        retiredFsm  = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        aluOp      = 2'b01;
        branch     = 1'b1;
        retiredFsm = 1'b1;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      S_HALT:  illegalFsm = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign IRWrite      = irWriteFsm  & ~reset;
  assign PCWrite      = (pcUpdate | (branch & zero)) & ~reset;
  assign RegWrite     = regWriteFsm & ~reset;
  assign MemWrite     = memWriteFsm & ~reset;
  assign InstrRetired = retiredFsm  & ~reset;
  assign IllegalOp    = illegalFsm  & ~reset;

  alu_decoder aluDec (
    .aluOp     (aluOp),
    .funct3    (funct3),
    .opB5      (op[5]),
    .funct7b5  (funct7b5),
    .aluControl(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven check of the multicycle controller; runs a
// fall-through (ILLEGAL_TRAP=0) and a halting (ILLEGAL_TRAP=1) instance side by side.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic [1:0] immSrc0, srcA0, srcB0, resSrc0, immSrc1, srcA1, srcB1, resSrc1;
  logic       adrSrc0, irW0, pcW0, regW0, memW0, ret0, ill0;
  logic       adrSrc1, irW1, pcW1, regW1, memW1, ret1, ill1;
  logic [2:0] aluCtl0, aluCtl1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.ILLEGAL_TRAP(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .ImmSrc(immSrc0), .ALUSrcA(srcA0), .ALUSrcB(srcB0), .ResultSrc(resSrc0), .AdrSrc(adrSrc0),
    .ALUControl(aluCtl0), .IRWrite(irW0), .PCWrite(pcW0), .RegWrite(regW0), .MemWrite(memW0),
    .InstrRetired(ret0), .IllegalOp(ill0)
  );

  multicycle_controller #(.ILLEGAL_TRAP(1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .ImmSrc(immSrc1), .ALUSrcA(srcA1), .ALUSrcB(srcB1), .ResultSrc(resSrc1), .AdrSrc(adrSrc1),
    .ALUControl(aluCtl1), .IRWrite(irW1), .PCWrite(pcW1), .RegWrite(regW1), .MemWrite(memW1),
    .InstrRetired(ret1), .IllegalOp(ill1)
  );

  // Packed as imm_A_B_res_adr_aluctl_ir_pcw_rw_mw_ret_ill
  wire [17:0] act0 = {immSrc0, srcA0, srcB0, resSrc0, adrSrc0, aluCtl0,
                      irW0, pcW0, regW0, memW0, ret0, ill0};
  wire [17:0] act1 = {immSrc1, srcA1, srcB1, resSrc1, adrSrc1, aluCtl1,
                      irW1, pcW1, regW1, memW1, ret1, ill1};

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BADOP = 7'b0000000;

  task automatic addVec(input string name, input logic rst, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic [17:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, advance past the rising edge
  task automatic step(input string name, input logic rst, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic chk0, input logic [17:0] exp0,
                      input logic chk1, input logic [17:0] exp1);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    @(negedge clk);
    if (chk0) check({name, "/t0"}, act0, exp0);
    if (chk1) check({name, "/t1"}, act1, exp1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;

    addVec("rst0",        1, LW, 3'b010, 0, 0, 18'b00_00_10_10_0_000_0_0_0_0_0_0);
    addVec("rst1",        1, LW, 3'b010, 0, 0, 18'b00_00_10_10_0_000_0_0_0_0_0_0);
    addVec("lw_fetch",    0, LW, 3'b010, 0, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("lw_decode",   0, LW, 3'b010, 0, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("lw_memadr",   0, LW, 3'b010, 0, 0, 18'b00_10_01_00_0_000_0_0_0_0_0_0);
    addVec("lw_memread",  0, LW, 3'b010, 0, 1, 18'b00_00_00_00_1_000_0_0_0_0_0_0);
    addVec("lw_memwb",    0, LW, 3'b010, 0, 1, 18'b00_00_00_01_0_000_0_0_1_0_1_0);
    addVec("sw_fetch",    0, SW, 3'b010, 0, 0, 18'b01_00_10_10_0_000_1_1_0_0_0_0);
    addVec("sw_decode",   0, SW, 3'b010, 0, 0, 18'b01_01_01_00_0_000_0_0_0_0_0_0);
    addVec("sw_memadr",   0, SW, 3'b010, 0, 0, 18'b01_10_01_00_0_000_0_0_0_0_0_0);
    addVec("sw_memwrite", 0, SW, 3'b010, 0, 0, 18'b01_00_00_00_1_000_0_0_0_1_1_0);
    addVec("sub_fetch",   0, RT, 3'b000, 1, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("sub_decode",  0, RT, 3'b000, 1, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("sub_execr",   0, RT, 3'b000, 1, 0, 18'b00_10_00_00_0_001_0_0_0_0_0_0);
    addVec("sub_aluwb",   0, RT, 3'b000, 1, 0, 18'b00_00_00_00_0_000_0_0_1_0_1_0);
    addVec("addi_fetch",  0, IT, 3'b000, 1, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("addi_decode", 0, IT, 3'b000, 1, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("addi_execi",  0, IT, 3'b000, 1, 0, 18'b00_10_01_00_0_000_0_0_0_0_0_0);
    addVec("addi_aluwb",  0, IT, 3'b000, 1, 0, 18'b00_00_00_00_0_000_0_0_1_0_1_0);
    addVec("or_fetch",    0, RT, 3'b110, 0, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("or_decode",   0, RT, 3'b110, 0, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("or_execr",    0, RT, 3'b110, 0, 0, 18'b00_10_00_00_0_011_0_0_0_0_0_0);
    addVec("or_aluwb",    0, RT, 3'b110, 0, 0, 18'b00_00_00_00_0_000_0_0_1_0_1_0);
    addVec("and_fetch",   0, RT, 3'b111, 0, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("and_decode",  0, RT, 3'b111, 0, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("and_execr",   0, RT, 3'b111, 0, 0, 18'b00_10_00_00_0_010_0_0_0_0_0_0);
    addVec("and_aluwb",   0, RT, 3'b111, 0, 0, 18'b00_00_00_00_0_000_0_0_1_0_1_0);
    addVec("slti_fetch",  0, IT, 3'b010, 1, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("slti_decode", 0, IT, 3'b010, 1, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("slti_execi",  0, IT, 3'b010, 1, 0, 18'b00_10_01_00_0_101_0_0_0_0_0_0);
    addVec("slti_aluwb",  0, IT, 3'b010, 1, 0, 18'b00_00_00_00_0_000_0_0_1_0_1_0);
    addVec("sll_fetch",   0, RT, 3'b001, 1, 0, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    addVec("sll_decode",  0, RT, 3'b001, 1, 0, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    addVec("sll_execr",   0, RT, 3'b001, 1, 0, 18'b00_10_00_00_0_000_0_0_0_0_0_0);
    addVec("sll_aluwb",   0, RT, 3'b001, 1, 0, 18'b00_00_00_00_0_000_0_0_1_0_1_0);
    addVec("beqt_fetch",  0, BQ, 3'b000, 0, 0, 18'b10_00_10_10_0_000_1_1_0_0_0_0);
    addVec("beqt_decode", 0, BQ, 3'b000, 0, 1, 18'b10_01_01_00_0_000_0_0_0_0_0_0);
    addVec("beqt_beq",    0, BQ, 3'b000, 0, 1, 18'b10_10_00_00_0_001_0_1_0_0_1_0);
    addVec("beqn_fetch",  0, BQ, 3'b000, 0, 1, 18'b10_00_10_10_0_000_1_1_0_0_0_0);
    addVec("beqn_decode", 0, BQ, 3'b000, 0, 1, 18'b10_01_01_00_0_000_0_0_0_0_0_0);
    addVec("beqn_beq",    0, BQ, 3'b000, 0, 0, 18'b10_10_00_00_0_001_0_0_0_0_1_0);
    addVec("jal_fetch",   0, JL, 3'b000, 0, 0, 18'b11_00_10_10_0_000_1_1_0_0_0_0);
    addVec("jal_decode",  0, JL, 3'b000, 0, 0, 18'b11_01_01_00_0_000_0_0_0_0_0_0);
    addVec("jal_jal",     0, JL, 3'b000, 0, 0, 18'b11_01_10_00_0_000_0_1_0_0_0_0);
    addVec("jal_aluwb",   0, JL, 3'b000, 0, 0, 18'b11_00_00_00_0_000_0_0_1_0_1_0);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z,
           1'b1, vecs[i].exp, 1'b1, vecs[i].exp);

    // Illegal opcode: instance 0 falls through to FETCH, instance 1 halts
    step("ill_fetch", 0, BADOP, 3'b000, 0, 0,
         1'b1, 18'b00_00_10_10_0_000_1_1_0_0_0_0, 1'b1, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    step("ill_decode", 0, BADOP, 3'b000, 0, 0,
         1'b1, 18'b00_01_01_00_0_000_0_0_0_0_1_1, 1'b1, 18'b00_01_01_00_0_000_0_0_0_0_0_1);
    step("ill_next", 0, BADOP, 3'b000, 0, 0,
         1'b1, 18'b00_00_10_10_0_000_1_1_0_0_0_0, 1'b1, 18'b00_00_00_00_0_000_0_0_0_0_0_1);
    for (int k = 0; k < 10; k++)
      step($sformatf("halt_hold%0d", k), 0, LW, 3'b010, 0, 1,
           1'b0, 18'b0, 1'b1, 18'b00_00_00_00_0_000_0_0_0_0_0_1);
    step("halt_rst", 1, LW, 3'b010, 0, 0,
         1'b1, 18'b00_00_10_10_0_000_0_0_0_0_0_0, 1'b1, 18'b00_00_10_10_0_000_0_0_0_0_0_0);
    step("halt_fetch", 0, LW, 3'b010, 0, 0,
         1'b1, 18'b00_00_10_10_0_000_1_1_0_0_0_0, 1'b1, 18'b00_00_10_10_0_000_1_1_0_0_0_0);
    step("lw2_decode", 0, LW, 3'b010, 0, 0,
         1'b1, 18'b00_01_01_00_0_000_0_0_0_0_0_0, 1'b1, 18'b00_01_01_00_0_000_0_0_0_0_0_0);
    step("lw2_rst", 1, LW, 3'b010, 0, 0,
         1'b1, 18'b00_00_10_10_0_000_0_0_0_0_0_0, 1'b1, 18'b00_00_10_10_0_000_0_0_0_0_0_0);

    // Reset arriving in MEMWRITE must kill MemWrite in the same cycle
    step("sw2_fetch", 0, SW, 3'b010, 0, 0,
         1'b1, 18'b01_00_10_10_0_000_1_1_0_0_0_0, 1'b1, 18'b01_00_10_10_0_000_1_1_0_0_0_0);
    step("sw2_decode", 0, SW, 3'b010, 0, 0,
         1'b1, 18'b01_01_01_00_0_000_0_0_0_0_0_0, 1'b1, 18'b01_01_01_00_0_000_0_0_0_0_0_0);
    step("sw2_memadr", 0, SW, 3'b010, 0, 0,
         1'b1, 18'b01_10_01_00_0_000_0_0_0_0_0_0, 1'b1, 18'b01_10_01_00_0_000_0_0_0_0_0_0);
    @(negedge clk);
    check("sw2_memwrite/t0", act0, 18'b01_00_00_00_1_000_0_0_0_1_1_0);
    reset = 1'b1;
    #1;
    check("sw2_rst_mid/t0", act0, 18'b01_00_10_10_0_000_0_0_0_0_0_0);
    check("sw2_rst_mid/t1", act1, 18'b01_00_10_10_0_000_0_0_0_0_0_0);
    @(posedge clk);
    #1;
    step("sw2_refetch", 0, SW, 3'b010, 0, 0,
         1'b1, 18'b01_00_10_10_0_000_1_1_0_0_0_0, 1'b1, 18'b01_00_10_10_0_000_1_1_0_0_0_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
